// File: rtl/my_defs.sv
// Shared definitions for the fetch sequencer: word width, default vectors and
// sequencer state encoding.
package my_defs;

  localparam int WORD = 32;

  localparam logic [WORD-1:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [WORD-1:0] DEF_EXC_VEC   = 32'h0000_0180;
  localparam int              DEF_TIMEOUT   = 8;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Instruction addresses must be word aligned.
  function automatic logic misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/my_pc_ctrl.sv
// Fetch sequencer beside my_pc: drives pc_d, runs the imem req/ack handshake,
// hands fetched words to decode and applies redirects, exceptions and faults.
module my_pc_ctrl
  import my_defs::*;
#(
  parameter logic [WORD-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [WORD-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int              TIMEOUT   = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] pc_q,
  output logic [WORD-1:0] pc_d,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic            if_valid,
  output logic [WORD-1:0] if_instr,
  output logic [WORD-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_target,
  input  logic            exc_req,
  output logic            fetch_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              pend_valid;
  logic              pend_exc;
  logic [WORD-1:0]   pend_target;

  logic              redir_ok;
  logic              redir_bad;
  logic              squash;
  logic [WORD-1:0]   squash_target;

  // exc_req outranks any redirect; a misaligned target only faults on its own.
  assign redir_ok  = redirect_valid && !misaligned(redirect_target[1:0]);
  assign redir_bad = redirect_valid && !exc_req && misaligned(redirect_target[1:0]);

  // A fetch in flight is thrown away if anything redirected it, this cycle or earlier.
  assign squash        = exc_req || redir_ok || pend_valid;
  assign squash_target = (exc_req || pend_exc) ? EXC_VEC :
                         redir_ok              ? redirect_target :
                                                 pend_target;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc_q;
  assign fetch_err = (state == ST_FAULT);

  // Next-PC mux. my_pc has no enable, so "hold" is pc_d = pc_q.
  always_comb begin
    // NOTE: default first so every path assigns pc_d and no latch is inferred.
    pc_d = pc_q;
    unique case (state)
      ST_BOOT:  pc_d = RESET_VEC;
      ST_FETCH: begin
        if (imem_ack && !redir_bad)
          pc_d = squash ? squash_target : pc_q + WORD'(4);
      end
      ST_HOLD: begin
        if (exc_req)       pc_d = EXC_VEC;
        else if (redir_ok) pc_d = redirect_target;
      end
      ST_FAULT: pc_d = EXC_VEC;
      default:  pc_d = pc_q;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_BOOT;
      cnt         <= '0;
      pend_valid  <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
    end else begin
      unique case (state)
        ST_BOOT: begin
          // imem_ack is deliberately not looked at: it may belong to a pre-reset fetch.
          state      <= ST_FETCH;
          cnt        <= '0;
          pend_valid <= 1'b0;
          pend_exc   <= 1'b0;
        end

        ST_FETCH: begin
          if (redir_bad) begin
            state      <= ST_FAULT;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
          end else if (imem_ack) begin
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            if (squash) begin
              state <= ST_FETCH;
            end else begin
              state    <= ST_HOLD;
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= pc_q;
            end
          end else if (cnt == CNT_LAST) begin
            state      <= ST_FAULT;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (exc_req) begin
              pend_valid <= 1'b1;
              pend_exc   <= 1'b1;
            end else if (redir_ok && !pend_exc) begin
              pend_valid  <= 1'b1;
              pend_target <= redirect_target;
            end
          end
        end

        ST_HOLD: begin
          if (exc_req || redir_ok) begin
            if_valid <= 1'b0;
            state    <= ST_FETCH;
          end else if (redir_bad) begin
            if_valid <= 1'b0;
            state    <= ST_FAULT;
          end else if (if_valid && id_ready) begin
            if_valid <= 1'b0;
            state    <= ST_FETCH;
          end
        end

        ST_FAULT: begin
          state <= ST_FETCH;
          cnt   <= '0;
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
